// File: rtl/coreuart_pkg.sv
// Shared types and constants for the CoreUART receive FIFO.
// COREUART_RXFIFO_ERRTAG_EN adds parity/framing tags to every stored entry.
package coreuart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int FIFO_DEPTH_MAX = 256;

`ifdef COREUART_RXFIFO_ERRTAG_EN
    localparam int ERRTAG_W = 2;

    typedef struct packed {
        logic                   parity_err;
        logic                   framing_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;
`else
    localparam int ERRTAG_W = 0;

    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;
`endif

    // One extra bit so a completely full FIFO is representable without wrapping.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/coreuart_rx_fifo_if.sv
// Receiver-to-FIFO-to-host signal bundle; master is the receiver/host side, slave is the FIFO.
interface coreuart_rx_fifo_if
    import coreuart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int LVL_W  = 5
);
    logic              wr_stb;
    logic [DATA_W-1:0] wr_data;
    logic              wr_parity_err;
    logic              wr_framing_err;
    logic              rd_en;
    logic              clr_overflow;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_parity_err;
    logic              rd_framing_err;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport master (
        output wr_stb, wr_data, wr_parity_err, wr_framing_err, rd_en, clr_overflow,
        input  rd_data, rd_valid, rd_parity_err, rd_framing_err,
        input  empty, full, almost_full, level, overflow
    );

    modport slave (
        input  wr_stb, wr_data, wr_parity_err, wr_framing_err, rd_en, clr_overflow,
        output rd_data, rd_valid, rd_parity_err, rd_framing_err,
        output empty, full, almost_full, level, overflow
    );
endinterface

// File: rtl/coreuart_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read.
module coreuart_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-address write this edge is not visible until the next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/coreuart_rx_fifo.sv
// UART receive FIFO: pointers, level/flags and sticky overflow around coreuart_fifo_ram.
// COREUART_RXFIFO_ERRTAG_EN stores and returns per-byte parity/framing tags.
module coreuart_rx_fifo
    import coreuart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = UART_DATA_W,
    parameter int AF_LEVEL = 12
) (
    input logic                CLK,
    input logic                RESET,
    coreuart_rx_fifo_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = level_w(DEPTH);
    localparam int ENTRY_W = DATA_W + ERRTAG_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);

    if (DEPTH < 4 || DEPTH > FIFO_DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("coreuart_rx_fifo: DEPTH must be a power of two in 4..256");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("coreuart_rx_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_q, full_q, af_q;
    logic             ovf_q, ovf_d;
    logic             rd_valid_q;
    logic             push, pop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    // When full, a coincident read frees the slot the write lands in.
    always_comb begin
        push     = bus.wr_stb && (!full_q || bus.rd_en);
        pop      = bus.rd_en && !empty_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        ovf_d    = ovf_q;
        if (bus.clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (bus.wr_stb && full_q && !bus.rd_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == LVL_FULL);
            af_q       <= (level_d >= LVL_AF);
            ovf_q      <= ovf_d;
            rd_valid_q <= pop;
        end
    end

    coreuart_fifo_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

`ifdef COREUART_RXFIFO_ERRTAG_EN
    assign wr_entry           = {bus.wr_parity_err, bus.wr_framing_err, bus.wr_data};
    assign bus.rd_data        = rd_entry[DATA_W-1:0];
    assign bus.rd_parity_err  = rd_entry[DATA_W+1];
    assign bus.rd_framing_err = rd_entry[DATA_W];
`else
    logic unused_err;
    assign unused_err         = bus.wr_parity_err ^ bus.wr_framing_err;
    assign wr_entry           = bus.wr_data;
    assign bus.rd_data        = rd_entry;
    assign bus.rd_parity_err  = 1'b0;
    assign bus.rd_framing_err = 1'b0;
`endif

    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.level       = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_coreuart_rx_fifo.sv
// Scoreboard bench for coreuart_rx_fifo (DEPTH 16, AF_LEVEL 12); honours COREUART_RXFIFO_ERRTAG_EN.
module tb_coreuart_rx_fifo;
    logic clk;
    logic rst;

    coreuart_rx_fifo_if #(.DATA_W(8), .LVL_W(5)) bus ();

    coreuart_rx_fifo #(.DEPTH(16), .DATA_W(8), .AF_LEVEL(12)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] mdl [$];
    logic [9:0] exp_q [$];
    logic       m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle; the model advances at the same edge the DUT does.
    task automatic step(input logic wr, input logic [7:0] d, input logic pe, input logic fe,
                        input logic rd, input logic clr);
        logic rd_ok, wr_ok, ov_set;
        logic [9:0] ent;
        bus.wr_stb = wr; bus.wr_data = d; bus.wr_parity_err = pe; bus.wr_framing_err = fe;
        bus.rd_en = rd; bus.clr_overflow = clr;
        @(posedge clk);
        rd_ok  = rd && (mdl.size() != 0);
        wr_ok  = wr && (mdl.size() < 16 || rd);
        ov_set = wr && (mdl.size() == 16) && !rd;
`ifdef COREUART_RXFIFO_ERRTAG_EN
        ent = {pe, fe, d};
`else
        ent = {2'b00, d};
`endif
        if (rd_ok) exp_q.push_back(mdl.pop_front());
        if (wr_ok) mdl.push_back(ent);
        if (ov_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        bus.wr_stb = 1'b0; bus.rd_en = 1'b0; bus.clr_overflow = 1'b0;
        bus.wr_parity_err = 1'b0; bus.wr_framing_err = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_level"}, int'(bus.level), mdl.size());
        chk({tag, "_empty"}, int'(bus.empty), int'(mdl.size() == 0));
        chk({tag, "_full"}, int'(bus.full), int'(mdl.size() == 16));
        chk({tag, "_af"}, int'(bus.almost_full), int'(mdl.size() >= 12));
        chk({tag, "_ovf"}, int'(bus.overflow), int'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        mdl.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every rd_valid must match the oldest expected pop, one cycle after the request.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", int'(bus.rd_data), int'(e[7:0]));
                    chk("rd_parity_err", int'(bus.rd_parity_err), int'(e[9]));
                    chk("rd_framing_err", int'(bus.rd_framing_err), int'(e[8]));
                end
            end
            if (exp_q.size() != 0) begin
                chk("rd_latency_pending", exp_q.size(), 0);
                exp_q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.wr_stb = 1'b0; bus.wr_data = '0; bus.wr_parity_err = 1'b0; bus.wr_framing_err = 1'b0;
        bus.rd_en = 1'b0; bus.clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_rd_data", int'(bus.rd_data), 0);
        chk("reset_rd_valid", int'(bus.rd_valid), 0);
        chk("reset_tags", int'({bus.rd_parity_err, bus.rd_framing_err}), 0);
        chk_flags("reset");

        // 1: simple write/read ordering
        wr(8'h41); wr(8'h42); wr(8'h43);
        chk("t1_level", int'(bus.level), 3);
        rd(); rd(); rd();
        chk("t1_empty", int'(bus.empty), 1);

        // 2: fill, almost_full threshold, overflow on 17th write
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            if (i == 10) chk("t2_af_at11", int'(bus.almost_full), 0);
            if (i == 11) chk("t2_af_at12", int'(bus.almost_full), 1);
        end
        chk("t2_full", int'(bus.full), 1);
        chk("t2_level", int'(bus.level), 16);
        wr(8'hAA);
        chk("t2_overflow", int'(bus.overflow), 1);
        chk_flags("t2");

        // 6a: clear coincident with new overflow keeps it set; lone clear drops it
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_set_wins", int'(bus.overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_clr", int'(bus.overflow), 0);

        // 3: full with simultaneous write and read
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_ovf", int'(bus.overflow), 0);
        chk("t3_level", int'(bus.level), 16);
        for (int i = 0; i < 16; i++) rd();
        chk_flags("t3_drained");
        chk("t3_last", int'(bus.rd_data), 8'h55);

        // 4: read on empty is ignored, then write+read on empty writes only
        rd();
        chk("t4_no_valid", int'(bus.rd_valid), 0);
        chk("t4_hold", int'(bus.rd_data), 8'h55);
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_level", int'(bus.level), 1);
        rd();

        // 5: error tags travel with their bytes
        step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        rd(); rd();
        chk_flags("t5");

        // 6b: reset with contents discards everything
        for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
        chk("t6_level5", int'(bus.level), 5);
        wr(8'hC0);
        do_reset();
        chk("t6_rst_empty", int'(bus.empty), 1);
        chk("t6_rst_level", int'(bus.level), 0);
        chk("t6_rst_rd_data", int'(bus.rd_data), 0);
        wr(8'h77);
        rd();
        chk_flags("t6_end");

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_expq", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
